calc_arbiter: RTL and testbench

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_arbiter_pkg.sv | 19 +
 rtl/calc_datapath.sv | 25 ++
 rtl/calc_arbiter.sv | 153 +++++++++++++++
 tb/tb_calc_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_arbiter_pkg.sv
// Shared constants for the round-robin calculator arbiter: opcodes, widths, FSM encoding.
package calc_arbiter_pkg;

    localparam int unsigned DW  = 8;
    localparam int unsigned SW  = 10;
    localparam int unsigned OPW = 2;

    localparam logic [OPW-1:0] OP_ADD   = 2'd0;
    localparam logic [OPW-1:0] OP_SUB_A = 2'd1;
    localparam logic [OPW-1:0] OP_SUB_B = 2'd2;
    localparam logic [OPW-1:0] OP_SUB_C = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/calc_datapath.sv
// Three-operand 10-bit adder; one operand optionally inverted (8-bit) with carry-in of 1.
module calc_datapath
    import calc_arbiter_pkg::*;
(
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic [DW-1:0]  c,
    input  logic [OPW-1:0] op,
    output logic [SW-1:0]  sum_c
);

    logic [DW-1:0] a_x;
    logic [DW-1:0] b_x;
    logic [DW-1:0] c_x;
    logic          cin;

    always_comb begin
        a_x   = (op == OP_SUB_A) ? ~a : a;
        b_x   = (op == OP_SUB_B) ? ~b : b;
        c_x   = (op == OP_SUB_C) ? ~c : c;
        cin   = (op != OP_ADD);
        sum_c = SW'(a_x) + SW'(b_x) + SW'(c_x) + SW'(cin);
    end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one calculator between NREQ requesters; IDLE -> EXEC -> RESP.
module calc_arbiter
    import calc_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_a,
    input  logic [NREQ*8-1:0]   req_b,
    input  logic [NREQ*8-1:0]   req_c,
    input  logic [NREQ*2-1:0]   req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_r,
    output logic [1:0]          rsp_carry,
    output logic                busy,
    output logic [15:0]         op_count
);

    state_e         state_q,     state_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic [DW-1:0]  a_q,         a_d;
    logic [DW-1:0]  b_q,         b_d;
    logic [DW-1:0]  c_q,         c_d;
    logic [OPW-1:0] op_q,        op_d;
    logic [IDW-1:0] rsp_id_q,    rsp_id_d;
    logic [7:0]     rsp_r_q,     rsp_r_d;
    logic [1:0]     rsp_carry_q, rsp_carry_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           busy_q,      busy_d;
    logic [15:0]    op_count_q,  op_count_d;

    logic [IDW-1:0] cand;
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic           accept;
    logic [SW-1:0]  sum;

    calc_datapath u_datapath (
        .a     (a_q),
        .b     (b_q),
        .c     (c_q),
        .op    (op_q),
        .sum_c (sum)
    );

    // Scan upward from ptr modulo NREQ; first valid requester wins.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    assign accept    = (state_q == ST_IDLE) && !rst && win_found;
    assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        op_d        = op_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
        rsp_carry_d = rsp_carry_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d      = req_a[{win_idx, 3'b000} +: 8];
                    b_d      = req_b[{win_idx, 3'b000} +: 8];
                    c_d      = req_c[{win_idx, 3'b000} +: 8];
                    op_d     = req_op[{win_idx, 1'b0} +: 2];
                    rsp_id_d = win_idx;
                    ptr_d    = IDW'((32'(win_idx) + 32'd1) % NREQ);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_r_d     = sum[7:0];
                rsp_carry_d = sum[9:8];
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            op_q        <= OP_ADD;
            rsp_id_q    <= '0;
            rsp_r_q     <= '0;
            rsp_carry_q <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            op_q        <= op_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_carry = rsp_carry_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed + randomized bench for calc_arbiter against an arithmetic reference model.
module tb_calc_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*8-1:0]   req_a;
    logic [NREQ*8-1:0]   req_b;
    logic [NREQ*8-1:0]   req_c;
    logic [NREQ*2-1:0]   req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_r;
    logic [1:0]          rsp_carry;
    logic                busy;
    logic [15:0]         op_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] ta  [NREQ];
    logic [7:0] tbv [NREQ];
    logic [7:0] tc  [NREQ];
    logic [1:0] top [NREQ];

    int mptr   = 0;
    int mcount = 0;

    calc_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_carry (rsp_carry),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8]  = ta[i];
            req_b[8*i +: 8]  = tbv[i];
            req_c[8*i +: 8]  = tc[i];
            req_op[2*i +: 2] = top[i];
        end
    endtask

    // Spec arithmetic with plain integers: subtract-by-complement of one operand, wrap at 1024.
    function automatic int model_sum(input int a, input int b, input int c, input int op);
        int x, y, z, cin;
        x = a; y = b; z = c; cin = 0;
        if (op == 1) begin x = 255 - a; cin = 1; end
        if (op == 2) begin y = 255 - b; cin = 1; end
        if (op == 3) begin z = 255 - c; cin = 1; end
        return (x + y + z + cin) % 1024;
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b, input int c, input int op);
        ta[i] = 8'(a); tbv[i] = 8'(b); tc[i] = 8'(c); top[i] = 2'(op);
    endtask

    // One full transaction: grant, EXEC, response (optionally stalled), handshake.
    task automatic run_one(input logic [NREQ-1:0] valid, input int stall, input bit keep);
        int w, s;
        pack_ops();
        req_valid = valid;
        rsp_ready = (stall == 0);
        #1;
        w = model_pick(valid);
        check("grant", 32'(req_ready), 32'(4'b0001 << w));
        check("idle_busy", 32'(busy), 32'd0);
        s = model_sum(int'(ta[w]), int'(tbv[w]), int'(tc[w]), int'(top[w]));
        @(posedge clk); #1;
        mptr = (w + 1) % NREQ;
        if (!keep) req_valid = '0;
        ta[w] = 8'($urandom); tbv[w] = 8'($urandom); top[w] = 2'($urandom);
        pack_ops();
        #1;
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(w));
        check("rsp_r", 32'(rsp_r), 32'(s % 256));
        check("rsp_carry", 32'(rsp_carry), 32'(s / 256));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_r", 32'(rsp_r), 32'(s % 256));
            check("stall_id", 32'(rsp_id), 32'(w));
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_count", 32'(op_count), 32'(mcount));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        mcount = (mcount + 1) % 65536;
        check("done_valid", 32'(rsp_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("op_count", 32'(op_count), 32'(mcount));
    endtask

    initial begin
        int w;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0);
        pack_ops();

        // Reset state, and req_ready held low while rst is high
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_r", 32'(rsp_r), 32'd0);
        check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        check("idle_none", 32'(req_ready), 32'd0);

        // All requesters continuously valid: grants 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) set_req(i, 10 * i + 1, 20 * i + 3, 7 * i, i);
        for (int n = 0; n < 5; n++) run_one(4'hF, 0, 1'b1);

        // Single request with each opcode, then wrap case
        for (int op = 0; op < 4; op++) begin
            set_req(0, 50, 60, 70, op);
            run_one(4'b0001, 0, 1'b0);
        end
        set_req(0, 255, 255, 255, 0);
        run_one(4'b0001, 0, 1'b0);

        // Backpressure for 5 cycles
        set_req(2, 200, 100, 33, 2);
        run_one(4'b0100, 5, 1'b0);

        // Reset during EXEC discards the transaction and the pointer
        set_req(1, 9, 9, 9, 0);
        run_one(4'b0010, 0, 1'b0);
        set_req(1, 9, 8, 7, 1);
        pack_ops();
        req_valid = 4'b0010;
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check("rst_exec_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        mptr = 0;
        mcount = 0;
        #1;
        check("rst_exec_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;
        check("rst_exec_norsp", 32'(rsp_valid), 32'd0);
        set_req(3, 1, 2, 3, 0);
        run_one(4'b1010, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
            w = int'($urandom_range(0, 3));
            run_one(4'($urandom_range(1, 15)), w, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
